// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Round-robin arbiter and response sequencer placed in front of a
//             single-port, byte-enabled RAM with 1-cycle read latency and no
//             output register. Master 0 is load/store, master 1 is fetch.
//             One access is accepted per cycle; the response for a grant is
//             returned exactly one cycle later to the granted master.
//  Ports    : clk, rst                        - clock, async active-high reset
//             mN_req/we/addr/wdata/be         - master N request (byte address)
//             mN_gnt                          - combinational accept
//             mN_rvalid/rdata/err             - master N response
//             ram_addr/wr_data/wr_en/wr_byte_en, ram_rd_data - RAM interface
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,   // must equal 8*BE_WIDTH
    parameter int BE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [BE_WIDTH-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [BE_WIDTH-1:0]   m1_be,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    // First byte-address bit above the RAM word range.
    localparam int c_HI_LSB = ADDR_WIDTH + 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_last_grant_q, w_last_grant_d;  // 1 = m1 won last
    logic [ADDR_WIDTH-1:0] r_ram_addr_q,   w_ram_addr_d;
    logic                  r_rsp_valid_q,  w_rsp_valid_d;
    logic                  r_rsp_sel_q,    w_rsp_sel_d;
    logic                  r_rsp_we_q,     w_rsp_we_d;
    logic                  r_rsp_err_q,    w_rsp_err_d;

    // ------------------------------------------------------------------------
    // Range check per master (upper byte-address bits must be zero)
    // ------------------------------------------------------------------------
    logic w_m0_in_range;
    logic w_m1_in_range;

    generate
        if (c_HI_LSB < 32) begin : g_range_chk
            assign w_m0_in_range = (m0_addr[31:c_HI_LSB] == '0);
            assign w_m1_in_range = (m1_addr[31:c_HI_LSB] == '0);
        end else begin : g_range_full
            assign w_m0_in_range = 1'b1;
            assign w_m1_in_range = 1'b1;
        end
    endgenerate

    // Byte-offset bits are intentionally ignored.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, m0_addr[1:0], m1_addr[1:0]};

    // ------------------------------------------------------------------------
    // Arbitration and selected-request mux
    // ------------------------------------------------------------------------
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_we;
    logic [31:0]           w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [BE_WIDTH-1:0]   w_sel_be;
    logic                  w_sel_in_range;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        // Grants are suppressed while reset is held so nothing reaches the RAM.
        if (!rst) begin
            if (m0_req && m1_req) begin
                // Conflict: the master that did not win last time goes now.
                if (r_last_grant_q) w_gnt0 = 1'b1;
                else                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
        w_any_gnt = w_gnt0 | w_gnt1;

        w_sel_we       = w_gnt1 ? m1_we         : m0_we;
        w_sel_addr     = w_gnt1 ? m1_addr       : m0_addr;
        w_sel_wdata    = w_gnt1 ? m1_wdata      : m0_wdata;
        w_sel_be       = w_gnt1 ? m1_be         : m0_be;
        w_sel_in_range = w_gnt1 ? w_m1_in_range : w_m0_in_range;

        w_last_grant_d = w_any_gnt ? w_gnt1 : r_last_grant_q;
        // Address holds its previous value on idle cycles.
        w_ram_addr_d   = w_any_gnt ? w_sel_addr[ADDR_WIDTH+1:2] : r_ram_addr_q;

        w_rsp_valid_d  = w_any_gnt;
        w_rsp_sel_d    = w_gnt1;
        w_rsp_we_d     = w_sel_we;
        w_rsp_err_d    = ~w_sel_in_range;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant_q <= 1'b1;   // m0 wins the first conflict
            r_ram_addr_q   <= '0;
            r_rsp_valid_q  <= 1'b0;
            r_rsp_sel_q    <= 1'b0;
            r_rsp_we_q     <= 1'b0;
            r_rsp_err_q    <= 1'b0;
        end else begin
            r_last_grant_q <= w_last_grant_d;
            r_ram_addr_q   <= w_ram_addr_d;
            r_rsp_valid_q  <= w_rsp_valid_d;
            r_rsp_sel_q    <= w_rsp_sel_d;
            r_rsp_we_q     <= w_rsp_we_d;
            r_rsp_err_q    <= w_rsp_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM drive
    // ------------------------------------------------------------------------
    assign m0_gnt         = w_gnt0;
    assign m1_gnt         = w_gnt1;
    assign ram_addr       = w_ram_addr_d;
    assign ram_wr_data    = w_sel_wdata;
    assign ram_wr_en      = w_any_gnt & w_sel_we & w_sel_in_range;
    assign ram_wr_byte_en = (w_any_gnt && w_sel_we) ? w_sel_be : '0;

    // ------------------------------------------------------------------------
    // Response: RAM data is only forwarded for in-range reads.
    // ------------------------------------------------------------------------
    logic w_rsp0;
    logic w_rsp1;
    logic w_rd_ok;

    assign w_rsp0  = r_rsp_valid_q & ~r_rsp_sel_q;
    assign w_rsp1  = r_rsp_valid_q &  r_rsp_sel_q;
    assign w_rd_ok = ~r_rsp_we_q & ~r_rsp_err_q;

    assign m0_rvalid = w_rsp0;
    assign m0_err    = w_rsp0 & r_rsp_err_q;
    assign m0_rdata  = (w_rsp0 && w_rd_ok) ? ram_rd_data : '0;

    assign m1_rvalid = w_rsp1;
    assign m1_err    = w_rsp1 & r_rsp_err_q;
    assign m1_rdata  = (w_rsp1 && w_rd_ok) ? ram_rd_data : '0;

endmodule
`default_nettype wire
